// File: rtl/sseg_pkg.sv
// sseg_pkg
// Shared seven-segment definitions used by both the display encoder and the
// capture/decode side:
//   SSEG_STABLE_DEFAULT - default number of identical samples before capture
//   SSEG_BLANK_N        - raw (active-low) segment bus value with all segments off
//   SSEG_GLYPH          - active-high gfedcba glyph codes for hex values 0..F
//   anode_onehot_low()  - true when exactly one active-low anode is asserted
//   sseg_glyph_code()   - hex value to active-high glyph code (encoder side)
package sseg_pkg;

    localparam int unsigned SSEG_STABLE_DEFAULT = 4;

    localparam logic [6:0] SSEG_BLANK_N = 7'h7F;

    localparam logic [6:0] SSEG_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic anode_onehot_low(input logic [3:0] anode);
        logic hit;
        case (anode)
            4'b1110: hit = 1'b1;
            4'b1101: hit = 1'b1;
            4'b1011: hit = 1'b1;
            4'b0111: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic [6:0] sseg_glyph_code(input logic [3:0] value);
        return SSEG_GLYPH[value];
    endfunction

endpackage

// File: rtl/sseg_to_hex.sv
// sseg_to_hex
// Combinational decode of a raw active-low 7-segment pattern (gfedcba).
// Ports:
//   seg   [6:0] in  - raw segment bus bits, active-low
//   hex   [3:0] out - decoded value, 0 when the pattern is not a glyph
//   known       out - pattern matches one of the sixteen glyphs
//   blank       out - all segments off
module sseg_to_hex (
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       known,
    output logic       blank
);
    import sseg_pkg::*;

    logic [6:0] seg_on_s;

    assign seg_on_s = ~seg;

    // Glyph codes are unique, so OR-accumulating the matches yields the single hit.
    always_comb begin
        hex   = 4'h0;
        known = 1'b0;
        blank = (seg == SSEG_BLANK_N);
        for (int i = 0; i < 16; i++) begin
            hex   = hex | ((seg_on_s == SSEG_GLYPH[i]) ? 4'(i) : 4'h0);
            known = known | (seg_on_s == SSEG_GLYPH[i]);
        end
    end

endmodule

// File: rtl/sseg_capture.sv
// sseg_capture
// Snoops a multiplexed 4-digit active-low seven-segment display bus and
// recovers the shown hex digits. A digit is captured once per stable run,
// when the same {Anode, SSeg} sample has been seen STABLE_CYCLES (2..15)
// consecutive edges with exactly one anode asserted.
// Ports:
//   clk          in  - system clock, rising edge
//   rst          in  - synchronous active-high reset
//   SSeg   [7:0] in  - bit 7 DP, bits 6:0 segments g..a, active-low
//   Anode  [3:0] in  - digit enables, active-low
//   Hex   [15:0] out - captured values, digit n in Hex[4n+3:4n]
//   DP     [3:0] out - captured decimal points, active-high
//   digit_valid  out - digit n last captured a recognised glyph
//   err    [3:0] out - digit n last captured a non-blank unknown pattern
//   frame_done   out - one-cycle pulse once all four digits were captured
module sseg_capture
    import sseg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = SSEG_STABLE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  SSeg,
    input  logic [3:0]  Anode,
    output logic [15:0] Hex,
    output logic [3:0]  DP,
    output logic [3:0]  digit_valid,
    output logic [3:0]  err,
    output logic        frame_done
);

    localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

    logic [11:0] sample_r;
    logic [3:0]  cnt_r;
    logic [3:0]  seen_r;
    logic [15:0] hex_r;
    logic [3:0]  dp_r;
    logic [3:0]  valid_r;
    logic [3:0]  err_r;
    logic        frame_done_r;

    logic        onehot_s;
    logic        same_s;
    logic        capture_s;
    logic [3:0]  cnt_nxt_s;
    logic [3:0]  cap_mask_s;
    logic [3:0]  seen_nxt_s;
    logic [15:0] hex_nxt_s;
    logic [3:0]  dp_nxt_s;
    logic [3:0]  valid_nxt_s;
    logic [3:0]  err_nxt_s;
    logic [3:0]  dec_hex_s;
    logic        dec_known_s;
    logic        dec_blank_s;

    sseg_to_hex u_dec (
        .seg   (SSeg[6:0]),
        .hex   (dec_hex_s),
        .known (dec_known_s),
        .blank (dec_blank_s)
    );

    assign onehot_s = anode_onehot_low(Anode);
    assign same_s   = ({Anode, SSeg} == sample_r);

    // Run-length counter: saturates so a held pattern reaches STABLE_C only once.
    always_comb begin
        cnt_nxt_s = 4'd0;
        if (!onehot_s) begin
            cnt_nxt_s = 4'd0;
        end else if (!same_s) begin
            cnt_nxt_s = 4'd1;
        end else if (cnt_r >= STABLE_C) begin
            cnt_nxt_s = STABLE_C;
        end else begin
            cnt_nxt_s = cnt_r + 4'd1;
        end
    end

    // Capture on the edge where the count first reaches STABLE_C.
    assign capture_s  = onehot_s && (cnt_nxt_s == STABLE_C) && (cnt_r != STABLE_C);
    assign cap_mask_s = capture_s ? ~Anode : 4'h0;

    // Per-digit output update and frame tracking for the capturing digit.
    always_comb begin
        hex_nxt_s   = hex_r;
        dp_nxt_s    = dp_r;
        valid_nxt_s = valid_r;
        err_nxt_s   = err_r;
        for (int n = 0; n < 4; n++) begin
            if (cap_mask_s[n]) begin
                dp_nxt_s[n]    = ~SSeg[7];
                valid_nxt_s[n] = dec_known_s;
                err_nxt_s[n]   = ~dec_known_s & ~dec_blank_s;
                if (dec_known_s) begin
                    hex_nxt_s[4*n +: 4] = dec_hex_s;
                end else begin
                    hex_nxt_s[4*n +: 4] = hex_r[4*n +: 4];
                end
            end else begin
                hex_nxt_s[4*n +: 4] = hex_r[4*n +: 4];
            end
        end
        // A full frame clears the seen bits, but a capture in the same cycle
        // already counts toward the next frame.
        if (seen_r == 4'hF) begin
            seen_nxt_s = cap_mask_s;
        end else begin
            seen_nxt_s = seen_r | cap_mask_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_r     <= 12'hFFF;
            cnt_r        <= 4'd0;
            seen_r       <= 4'h0;
            hex_r        <= 16'h0000;
            dp_r         <= 4'h0;
            valid_r      <= 4'h0;
            err_r        <= 4'h0;
            frame_done_r <= 1'b0;
        end else begin
            sample_r     <= {Anode, SSeg};
            cnt_r        <= cnt_nxt_s;
            seen_r       <= seen_nxt_s;
            hex_r        <= hex_nxt_s;
            dp_r         <= dp_nxt_s;
            valid_r      <= valid_nxt_s;
            err_r        <= err_nxt_s;
            frame_done_r <= (seen_r == 4'hF);
        end
    end

    assign Hex         = hex_r;
    assign DP          = dp_r;
    assign digit_valid = valid_r;
    assign err         = err_r;
    assign frame_done  = frame_done_r;

endmodule
